// File: rtl/fu_wakeup_arbiter_if.sv
// Wakeup-bus bundle between N_FU functional units / dispatch and the wakeup arbiter.
interface fu_wakeup_arbiter_if #(
  parameter int N_FU = 4
);
  logic                 flush;
  logic [N_FU-1:0]      fu_wakeup_active;
  logic [6*N_FU-1:0]    fu_wakeup_rob_index;
  logic [6*N_FU-1:0]    fu_wakeup_tag;
  logic [32*N_FU-1:0]   fu_wakeup_value;
  logic [N_FU-1:0]      fu_dispatch_ok;
  logic                 wakeup_active;
  logic [5:0]           wakeup_rob_index;
  logic [5:0]           wakeup_tag;
  logic [31:0]          wakeup_value;
  logic [2:0]           wakeup_fu;
  logic [3:0]           pending_count;
  logic                 overflow;

  modport master (
    output flush, fu_wakeup_active, fu_wakeup_rob_index, fu_wakeup_tag, fu_wakeup_value,
    input  fu_dispatch_ok, wakeup_active, wakeup_rob_index, wakeup_tag, wakeup_value,
           wakeup_fu, pending_count, overflow
  );

  modport slave (
    input  flush, fu_wakeup_active, fu_wakeup_rob_index, fu_wakeup_tag, fu_wakeup_value,
    output fu_dispatch_ok, wakeup_active, wakeup_rob_index, wakeup_tag, wakeup_value,
           wakeup_fu, pending_count, overflow
  );
endinterface

// File: rtl/fu_wakeup_arbiter.sv
// Captures one-cycle FU completion pulses into per-FU slots and drains them
// round-robin, one per cycle, onto the shared wakeup bus.
module fu_wakeup_arbiter #(
  parameter int N_FU = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fu_wakeup_arbiter_if.slave    io
);
  localparam int unsigned PTR_W = $clog2(N_FU);
  localparam int unsigned IDX_W = 6;
  localparam int unsigned VAL_W = 32;
  localparam int unsigned CNT_W = 4;

  logic [N_FU-1:0]   r_valid;
  logic [IDX_W-1:0]  r_rob   [N_FU];
  logic [IDX_W-1:0]  r_tag   [N_FU];
  logic [VAL_W-1:0]  r_value [N_FU];
  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_overflow;

  logic              w_found;
  logic [PTR_W-1:0]  w_win;
  logic [PTR_W-1:0]  w_idx;
  logic [N_FU-1:0]   w_grant;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_ovf;

  // Round-robin pick: scan from the far end back so the slot nearest rr_ptr wins last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_grant = '0;
    for (int k = N_FU - 1; k >= 0; k--) begin
      w_idx = PTR_W'((int'(r_rr_ptr) + k) % N_FU);
      if (r_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_grant[w_win] = w_found;
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N_FU; i++) begin
      w_cnt = w_cnt + CNT_W'(r_valid[i]);
    end
  end

  // A completion landing on a held, ungranted slot would lose the older result.
  assign w_ovf = !io.flush && (|(io.fu_wakeup_active & r_valid & ~w_grant));

  assign io.wakeup_active    = w_found;
  assign io.wakeup_rob_index = r_rob[w_win];
  assign io.wakeup_tag       = r_tag[w_win];
  assign io.wakeup_value     = r_value[w_win];
  assign io.wakeup_fu        = 3'(w_win);
  assign io.fu_dispatch_ok   = ~r_valid | w_grant;
  assign io.pending_count    = w_cnt;
  assign io.overflow         = r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= '0;
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < N_FU; i++) begin
        r_rob[i]   <= '1;
        r_tag[i]   <= '0;
        r_value[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (io.flush) begin
          r_valid[i] <= 1'b0;
        end else if (io.fu_wakeup_active[i]) begin
          r_valid[i] <= 1'b1;
          r_rob[i]   <= io.fu_wakeup_rob_index[IDX_W*i +: IDX_W];
          r_tag[i]   <= io.fu_wakeup_tag[IDX_W*i +: IDX_W];
          r_value[i] <= io.fu_wakeup_value[VAL_W*i +: VAL_W];
        end else if (w_grant[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (!io.flush && w_found) begin
        r_rr_ptr <= (w_win == PTR_W'(N_FU - 1)) ? '0 : w_win + PTR_W'(1);
      end
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fu_wakeup_arbiter.sv
// Directed bench for fu_wakeup_arbiter: single result, contention, rotation,
// back-to-back reload, flush, overflow and asynchronous reset.
module tb_fu_wakeup_arbiter;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  fu_wakeup_arbiter_if #(.N_FU(4)) bus ();

  fu_wakeup_arbiter #(.N_FU(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fu(input int i, input logic [5:0] rob, input logic [5:0] tag,
                        input logic [31:0] val);
    bus.fu_wakeup_active[i]             = 1'b1;
    bus.fu_wakeup_rob_index[6*i +: 6]   = rob;
    bus.fu_wakeup_tag[6*i +: 6]         = tag;
    bus.fu_wakeup_value[32*i +: 32]     = val;
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.fu_wakeup_active = '0;
    bus.flush            = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.flush               = 1'b0;
    bus.fu_wakeup_active    = '0;
    bus.fu_wakeup_rob_index = '0;
    bus.fu_wakeup_tag       = '0;
    bus.fu_wakeup_value     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_active",  32'(bus.wakeup_active), 0);
    chk("rst_ok",      32'(bus.fu_dispatch_ok), 32'hF);
    chk("rst_pending", 32'(bus.pending_count), 0);
    chk("rst_ovf",     32'(bus.overflow), 0);
    chk("rst_rob",     32'(bus.wakeup_rob_index), 32'h3F);
    chk("rst_fu",      32'(bus.wakeup_fu), 0);
    chk("rst_value",   32'(bus.wakeup_value), 0);
    reset = 1'b1;

    // Single result on FU2
    set_fu(2, 6'd5, 6'd9, 32'h1234);
    cyc();
    chk("single_active", 32'(bus.wakeup_active), 1);
    chk("single_fu",     32'(bus.wakeup_fu), 2);
    chk("single_rob",    32'(bus.wakeup_rob_index), 5);
    chk("single_tag",    32'(bus.wakeup_tag), 9);
    chk("single_value",  32'(bus.wakeup_value), 32'h1234);
    chk("single_pend",   32'(bus.pending_count), 1);
    chk("single_ok",     32'(bus.fu_dispatch_ok), 32'hF);
    cyc();
    chk("single_idle",   32'(bus.wakeup_active), 0);
    chk("single_pend0",  32'(bus.pending_count), 0);

    // Contention from rr_ptr=0
    do_reset();
    for (int i = 0; i < 4; i++) set_fu(i, 6'(10 + i), 6'(20 + i), 32'hA0 + 32'(i));
    cyc();
    chk("cont0_fu",   32'(bus.wakeup_fu), 0);
    chk("cont0_pend", 32'(bus.pending_count), 4);
    chk("cont0_ok",   32'(bus.fu_dispatch_ok), 32'h1);
    chk("cont0_val",  32'(bus.wakeup_value), 32'hA0);
    cyc();
    chk("cont1_fu",   32'(bus.wakeup_fu), 1);
    chk("cont1_pend", 32'(bus.pending_count), 3);
    chk("cont1_ok",   32'(bus.fu_dispatch_ok), 32'h3);
    cyc();
    chk("cont2_fu",   32'(bus.wakeup_fu), 2);
    chk("cont2_pend", 32'(bus.pending_count), 2);
    chk("cont2_ok",   32'(bus.fu_dispatch_ok), 32'h7);
    cyc();
    chk("cont3_fu",   32'(bus.wakeup_fu), 3);
    chk("cont3_pend", 32'(bus.pending_count), 1);
    chk("cont3_ok",   32'(bus.fu_dispatch_ok), 32'hF);
    chk("cont3_tag",  32'(bus.wakeup_tag), 23);
    chk("cont3_rob",  32'(bus.wakeup_rob_index), 13);
    cyc();
    chk("cont_idle",  32'(bus.wakeup_active), 0);
    chk("cont_pend0", 32'(bus.pending_count), 0);

    // Rotation: FU1 grant leaves rr_ptr=2, then FU0+FU3 -> FU3 first
    set_fu(1, 6'd1, 6'd1, 32'h11);
    cyc();
    chk("rot_fu1", 32'(bus.wakeup_fu), 1);
    cyc();
    set_fu(0, 6'd2, 6'd2, 32'h22);
    set_fu(3, 6'd3, 6'd3, 32'h33);
    cyc();
    chk("rot_first",  32'(bus.wakeup_fu), 3);
    chk("rot_fval",   32'(bus.wakeup_value), 32'h33);
    cyc();
    chk("rot_second", 32'(bus.wakeup_fu), 0);
    chk("rot_sval",   32'(bus.wakeup_value), 32'h22);
    cyc();
    chk("rot_idle",   32'(bus.wakeup_active), 0);

    // Back-to-back reload of FU1 (rr_ptr=1)
    set_fu(1, 6'd33, 6'd1, 32'd111);
    cyc();
    chk("b2b_k_fu",  32'(bus.wakeup_fu), 1);
    chk("b2b_k_ok",  32'(bus.fu_dispatch_ok), 32'hF);
    cyc();
    set_fu(1, 6'd34, 6'd2, 32'd222);
    cyc();
    chk("b2b_k2_act", 32'(bus.wakeup_active), 1);
    chk("b2b_k2_val", 32'(bus.wakeup_value), 32'd222);
    set_fu(1, 6'd35, 6'd3, 32'd333);
    cyc();
    chk("b2b_k3_fu",   32'(bus.wakeup_fu), 1);
    chk("b2b_k3_val",  32'(bus.wakeup_value), 32'd333);
    chk("b2b_k3_pend", 32'(bus.pending_count), 1);
    chk("b2b_ovf",     32'(bus.overflow), 0);
    cyc();
    chk("b2b_idle",    32'(bus.wakeup_active), 0);

    // Flush with three slots valid (rr_ptr=2) while FU0 pulses
    set_fu(1, 6'd4, 6'd4, 32'h44);
    set_fu(2, 6'd5, 6'd5, 32'h55);
    set_fu(3, 6'd6, 6'd6, 32'h66);
    cyc();
    chk("fl_pre_fu",   32'(bus.wakeup_fu), 2);
    chk("fl_pre_pend", 32'(bus.pending_count), 3);
    bus.flush = 1'b1;
    set_fu(0, 6'd7, 6'd7, 32'h77);
    cyc();
    chk("fl_pend",   32'(bus.pending_count), 0);
    chk("fl_active", 32'(bus.wakeup_active), 0);
    chk("fl_ok",     32'(bus.fu_dispatch_ok), 32'hF);
    set_fu(1, 6'd8, 6'd8, 32'h88);
    set_fu(2, 6'd9, 6'd9, 32'h99);
    cyc();
    chk("fl_rr_first",  32'(bus.wakeup_fu), 2);
    cyc();
    chk("fl_rr_second", 32'(bus.wakeup_fu), 1);
    cyc();

    // Overflow: rr_ptr=2 -> FU0 grant moves it to 1
    set_fu(0, 6'd10, 6'd10, 32'hAA);
    cyc();
    chk("ov_pre_fu", 32'(bus.wakeup_fu), 0);
    cyc();
    for (int i = 0; i < 4; i++) set_fu(i, 6'(40 + i), 6'(40 + i), 32'hB0 + 32'(i));
    cyc();
    chk("ov_g1_fu",  32'(bus.wakeup_fu), 1);
    chk("ov_g1_ovf", 32'(bus.overflow), 0);
    set_fu(0, 6'd50, 6'd50, 32'hC0);
    cyc();
    chk("ov_flag",   32'(bus.overflow), 1);
    chk("ov_fu",     32'(bus.wakeup_fu), 2);
    chk("ov_pend",   32'(bus.pending_count), 3);
    cyc();
    cyc();
    chk("ov_new_fu",  32'(bus.wakeup_fu), 0);
    chk("ov_new_val", 32'(bus.wakeup_value), 32'hC0);
    chk("ov_sticky",  32'(bus.overflow), 1);

    // Asynchronous reset mid-cycle with slots held
    for (int i = 0; i < 4; i++) set_fu(i, 6'(i), 6'(i), 32'(i));
    cyc();
    chk("ar_pre_pend", 32'(bus.pending_count), 4);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_active", 32'(bus.wakeup_active), 0);
    chk("ar_ok",     32'(bus.fu_dispatch_ok), 32'hF);
    chk("ar_pend",   32'(bus.pending_count), 0);
    chk("ar_ovf",    32'(bus.overflow), 0);
    chk("ar_rob",    32'(bus.wakeup_rob_index), 32'h3F);
    chk("ar_fu",     32'(bus.wakeup_fu), 0);
    reset = 1'b1;
    cyc();
    chk("ar_after",  32'(bus.wakeup_active), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
